prog_loader: RTL and testbench

- Boot-time program loader upstream of the single-cycle MIPS core's instruction memory.
- Takes a byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Writes each word into instruction memory at consecutive word addresses, then checks a trailing XOR checksum.
- Holds the core stopped until the load completes cleanly, then asserts core_run.

---
 rtl/mips_pkg.sv | 17 +
 rtl/prog_loader_byte_packer.sv | 39 +++
 rtl/prog_loader.sv | 140 ++++++++++++++
 tb/tb_prog_loader.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS boot path: loader state encoding and bus widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    LD_HDR  = 3'd0,
    LD_DATA = 3'd1,
    LD_CSUM = 3'd2,
    LD_DONE = 3'd3,
    LD_ERR  = 3'd4
  } ld_state_e;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Packs accepted stream bytes into big-endian words (first byte lands in [31:24]).
// Latency: combinational; o_word/o_word_done are valid in the cycle of the 4th byte's accept.
// Backpressure: none of its own; the parent decides acceptance through i_accept.
// Ports: i_clr clears a partial word, i_accept marks a consumed byte on i_byte,
//        o_word is the assembled word, o_word_done flags the 4th byte of a word.
module byte_packer
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_accept,
  input  logic [BYTE_W-1:0] i_byte,
  output logic [WORD_W-1:0] o_word,
  output logic              o_word_done
);

  logic [1:0]  r_byte_cnt;
  logic [23:0] r_shift;

  // The completed word is formed from the three held bytes plus the byte being
  // accepted now, so the parent can act on it at the same clock edge.
  assign o_word      = {r_shift, i_byte};
  assign o_word_done = i_accept && (r_byte_cnt == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_cnt <= 2'd0;
      r_shift    <= 24'd0;
    end else if (i_clr) begin
      r_byte_cnt <= 2'd0;
      r_shift    <= 24'd0;
    end else if (i_accept) begin
      r_byte_cnt <= r_byte_cnt + 2'd1;  // wraps 3 -> 0 naturally
      r_shift    <= {r_shift[15:0], i_byte};
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Boot loader: streams a length header, N program words and an XOR checksum into imem.
// Latency: each data word's im_we fires one cycle after the edge accepting its last byte.
// Backpressure: in_ready high in HDR/DATA/CSUM (never stalls), low in DONE/ERR and reset.
// Ports: in_data/in_valid/in_ready byte stream; restart re-arms from DONE/ERR;
//        im_we/im_addr/im_wdata imem write port; core_run, load_err, words_loaded status.
module prog_loader
  import mips_pkg::*;
#(
  parameter int          MAX_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000  // must be word-aligned
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              restart,
  output logic              im_we,
  output logic [WORD_W-1:0] im_addr,
  output logic [WORD_W-1:0] im_wdata,
  output logic              core_run,
  output logic              load_err,
  output logic [15:0]       words_loaded
);

  localparam logic [WORD_W-1:0] MAX_W = WORD_W'(MAX_WORDS);

  ld_state_e         r_state;
  logic [15:0]       r_n;
  logic [15:0]       r_word_cnt;
  logic [WORD_W-1:0] r_csum;
  logic              r_in_ready;
  logic              r_im_we;
  logic [WORD_W-1:0] r_im_addr;
  logic [WORD_W-1:0] r_im_wdata;
  logic              r_core_run;
  logic              r_load_err;

  logic              w_accept;
  logic              w_word_done;
  logic [WORD_W-1:0] w_word;
  logic              w_rearm;
  logic [15:0]       w_cnt_nxt;

  assign w_accept  = in_valid && r_in_ready;
  assign w_rearm   = restart && ((r_state == LD_DONE) || (r_state == LD_ERR));
  assign w_cnt_nxt = r_word_cnt + 16'd1;

  byte_packer u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr       (w_rearm),
    .i_accept    (w_accept),
    .i_byte      (in_data),
    .o_word      (w_word),
    .o_word_done (w_word_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= LD_HDR;
      r_n        <= 16'd0;
      r_word_cnt <= 16'd0;
      r_csum     <= '0;
      r_in_ready <= 1'b0;
      r_im_we    <= 1'b0;
      r_im_addr  <= BASE_ADDR;
      r_im_wdata <= '0;
      r_core_run <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_im_we <= 1'b0;
      case (r_state)
        LD_HDR: begin
          // in_ready comes up the first cycle after reset release
          r_in_ready <= 1'b1;
          if (w_word_done) begin
            if (w_word > MAX_W) begin
              r_state    <= LD_ERR;
              r_in_ready <= 1'b0;
              r_load_err <= 1'b1;
            end else if (w_word == '0) begin
              r_state <= LD_CSUM;
            end else begin
              r_n     <= w_word[15:0];  // fits: bounded by MAX_WORDS
              r_state <= LD_DATA;
            end
          end
        end
        LD_DATA: begin
          if (w_word_done) begin
            r_im_we    <= 1'b1;
            r_im_wdata <= w_word;
            r_im_addr  <= BASE_ADDR + {14'd0, r_word_cnt, 2'b00};
            r_csum     <= r_csum ^ w_word;
            r_word_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == r_n) r_state <= LD_CSUM;
          end
        end
        LD_CSUM: begin
          if (w_word_done) begin
            r_in_ready <= 1'b0;
            if (w_word == r_csum) begin
              r_state    <= LD_DONE;
              r_core_run <= 1'b1;
            end else begin
              r_state    <= LD_ERR;
              r_load_err <= 1'b1;
              r_core_run <= 1'b0;
            end
          end
        end
        LD_DONE, LD_ERR: begin
          if (restart) begin
            r_state    <= LD_HDR;
            r_in_ready <= 1'b1;
            r_n        <= 16'd0;
            r_word_cnt <= 16'd0;
            r_csum     <= '0;
            r_core_run <= 1'b0;
            r_load_err <= 1'b0;
          end
        end
        default: begin
          r_state    <= LD_HDR;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign im_we        = r_im_we;
  assign im_addr      = r_im_addr;
  assign im_wdata     = r_im_wdata;
  assign core_run     = r_core_run;
  assign load_err     = r_load_err;
  assign words_loaded = r_word_cnt;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        restart;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic        core_run;
  logic        load_err;
  logic [15:0] words_loaded;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  int          ws_q[$];

  prog_loader #(.MAX_WORDS(256), .BASE_ADDR(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .restart      (restart),
    .im_we        (im_we),
    .im_addr      (im_addr),
    .im_wdata     (im_wdata),
    .core_run     (core_run),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every write strobe with the cycle stamp seen at the falling edge.
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      wa_q.push_back(im_addr);
      wd_q.push_back(im_wdata);
      ws_q.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one byte after an optional idle gap; returns the cycle stamp of the
  // cycle whose closing edge accepts it. Leaves in_valid high on exit.
  task automatic send_byte(input logic [7:0] b, input int gap, output int stamp);
    bit got;
    @(negedge clk);
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    in_data  = b;
    in_valid = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (in_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) chk("accept_timeout", {31'd0, in_ready}, 32'd1);
    stamp = cyc;
    @(posedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap, output int stamp);
    int st;
    for (int i = 0; i < 4; i++) begin
      send_byte(w[31-8*i -: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0, st);
    end
    stamp = st;
  endtask

  task automatic run_load(input int maxgap, input logic [31:0] cs, output int s1, output int s2);
    int st;
    send_word(32'h0000_0002, maxgap, st);
    send_word(32'h2408_0005, maxgap, s1);
    send_word(32'h0000_0000, maxgap, s2);
    send_word(cs, maxgap, st);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear_q();
    wa_q.delete();
    wd_q.delete();
    ws_q.delete();
  endtask

  task automatic chk_normal_writes(input string p, input int s1, input int s2);
    chk({p, "_nwr"},   ws_q.size(), 32'd2);
    chk({p, "_addr0"}, wa_q[0], 32'h0000_0000);
    chk({p, "_data0"}, wd_q[0], 32'h2408_0005);
    chk({p, "_addr1"}, wa_q[1], 32'h0000_0004);
    chk({p, "_data1"}, wd_q[1], 32'h0000_0000);
    chk({p, "_lat0"},  ws_q[0], s1 + 1);
    chk({p, "_lat1"},  ws_q[1], s2 + 1);
  endtask

  initial begin
    int s1, s2, st;
    rst_n    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    restart  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_im_we",    {31'd0, im_we},    32'd0);
    chk("rst_im_addr",  im_addr,           32'h0);
    chk("rst_im_wdata", im_wdata,          32'h0);
    chk("rst_core_run", {31'd0, core_run}, 32'd0);
    chk("rst_load_err", {31'd0, load_err}, 32'd0);
    chk("rst_words",    {16'd0, words_loaded}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);

    // Normal load, back-to-back bytes
    clear_q();
    run_load(0, 32'h2408_0005, s1, s2);
    chk_normal_writes("t1", s1, s2);
    chk("t1_words",    {16'd0, words_loaded}, 32'd2);
    chk("t1_core_run", {31'd0, core_run},     32'd1);
    chk("t1_load_err", {31'd0, load_err},     32'd0);
    chk("t1_in_ready", {31'd0, in_ready},     32'd0);
    pulse_restart();

    // Bad checksum
    clear_q();
    run_load(0, 32'h2408_0006, s1, s2);
    chk_normal_writes("t2", s1, s2);
    chk("t2_load_err", {31'd0, load_err}, 32'd1);
    chk("t2_core_run", {31'd0, core_run}, 32'd0);
    chk("t2_in_ready", {31'd0, in_ready}, 32'd0);
    pulse_restart();
    chk("t2_rearm_err",   {31'd0, load_err},     32'd0);
    chk("t2_rearm_words", {16'd0, words_loaded}, 32'd0);

    // Oversize header
    clear_q();
    send_word(32'h0000_0101, 0, st);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("t3_load_err", {31'd0, load_err}, 32'd1);
    chk("t3_in_ready", {31'd0, in_ready}, 32'd0);
    chk("t3_nwr",      ws_q.size(),       32'd0);
    pulse_restart();

    // Header exactly MAX_WORDS is accepted (stay in loading state)
    clear_q();
    send_word(32'h0000_0100, 0, st);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("t3b_load_err", {31'd0, load_err}, 32'd0);
    chk("t3b_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Zero-length program
    clear_q();
    send_word(32'h0000_0000, 0, st);
    send_word(32'h0000_0000, 0, st);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("t4_core_run", {31'd0, core_run}, 32'd1);
    chk("t4_load_err", {31'd0, load_err}, 32'd0);
    chk("t4_nwr",      ws_q.size(),       32'd0);
    pulse_restart();
    chk("t4_rs_core_run", {31'd0, core_run},     32'd0);
    chk("t4_rs_in_ready", {31'd0, in_ready},     32'd1);
    chk("t4_rs_words",    {16'd0, words_loaded}, 32'd0);

    // Throttled normal load
    clear_q();
    run_load(3, 32'h2408_0005, s1, s2);
    chk_normal_writes("t5", s1, s2);
    chk("t5_core_run", {31'd0, core_run}, 32'd1);
    pulse_restart();

    // Reset in the middle of the first data word
    clear_q();
    send_word(32'h0000_0002, 0, st);
    send_byte(8'h24, 0, st);
    send_byte(8'h08, 0, st);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_in_ready", {31'd0, in_ready},     32'd0);
    chk("t6_rst_im_we",    {31'd0, im_we},        32'd0);
    chk("t6_rst_im_addr",  im_addr,               32'h0);
    chk("t6_rst_words",    {16'd0, words_loaded}, 32'd0);
    chk("t6_rst_core_run", {31'd0, core_run},     32'd0);
    chk("t6_nwr_partial",  ws_q.size(),           32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    clear_q();
    run_load(0, 32'h2408_0005, s1, s2);
    chk_normal_writes("t6", s1, s2);
    chk("t6_core_run", {31'd0, core_run}, 32'd1);
    chk("t6_load_err", {31'd0, load_err}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
